// File: rtl/resize_stream.sv
// resize_stream: multi-lane fixed-point recast with run-time shift, selectable
// rounding, saturate/wrap and per-lane sticky overflow flags. Three register
// stages (align, round, range) share one enable so backpressure stalls the
// whole pipe; each stage carries the config its sample was accepted with.
module resize_stream #(
    parameter int DIN_WIDTH   = 18,
    parameter int DIN_POINT   = 16,
    parameter int DOUT_WIDTH  = 9,
    parameter int DOUT_POINT  = 8,
    parameter     DATA_TYPE   = "signed",
    parameter int PARALLEL    = 4,
    parameter int MAX_SHIFT   = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DIN_WIDTH*PARALLEL-1:0]       din,
    input  logic                                din_valid,
    output logic                                din_ready,
    input  logic                                sync_in,
    output logic [DOUT_WIDTH*PARALLEL-1:0]      dout,
    output logic                                dout_valid,
    input  logic                                dout_ready,
    output logic                                sync_out,
    input  logic                                cfg_we,
    input  logic signed [SHIFT_WIDTH-1:0]       cfg_shift,
    input  logic [1:0]                          cfg_round,
    input  logic                                cfg_sat,
    input  logic                                warn_clr,
    output logic [PARALLEL-1:0]                 warn_flags,
    output logic                                warning
);

    localparam int  FRAC_DROP = DIN_POINT + MAX_SHIFT - DOUT_POINT;
    localparam int  F         = FRAC_DROP;
    // aligned width; one extra top bit keeps unsigned data positive when held signed
    localparam int  XW        = DIN_WIDTH + 2 * MAX_SHIFT;
    // rounded width: aligned + 1 guard bit, minus dropped fraction
    localparam int  YW        = XW + 2 - F;
    localparam int  SAW       = $clog2(2 * MAX_SHIFT + 1);
    localparam bit  IS_SIGNED = (DATA_TYPE == "signed");
    localparam int  HI_I      = IS_SIGNED ? (2 ** (DOUT_WIDTH - 1) - 1) : (2 ** DOUT_WIDTH - 1);
    localparam int  LO_I      = IS_SIGNED ? -(2 ** (DOUT_WIDTH - 1)) : 0;
    localparam logic signed [YW-1:0] HI   = YW'(HI_I);
    localparam logic signed [YW-1:0] LO   = YW'(LO_I);
    localparam logic        [XW+1:0] HALF = (XW + 2)'(1) << (F - 1);

    if (FRAC_DROP < 1) begin : g_bad_frac
        $error("resize_stream: DIN_POINT+MAX_SHIFT-DOUT_POINT must be at least 1");
    end
    if (MAX_SHIFT > 2 ** (SHIFT_WIDTH - 1) - 1) begin : g_bad_shift
        $error("resize_stream: SHIFT_WIDTH cannot hold +/-MAX_SHIFT");
    end
    if (YW <= DOUT_WIDTH) begin : g_bad_width
        $error("resize_stream: output wider than rounded intermediate");
    end
    if (DATA_TYPE != "signed" && DATA_TYPE != "unsigned") begin : g_bad_type
        $error("resize_stream: DATA_TYPE must be \"signed\" or \"unsigned\"");
    end

    logic                          en;
    logic signed [SHIFT_WIDTH-1:0] cfg_shift_q;
    logic [1:0]                    cfg_round_q;
    logic                          cfg_sat_q;
    logic [SAW-1:0]                sh_amt;

    logic signed [XW:0]            x_next [PARALLEL];
    logic signed [XW:0]            s1_x   [PARALLEL];
    logic                          s1_valid, s1_sync, s1_sat;
    logic [1:0]                    s1_round;

    logic signed [XW+1:0]          rsum   [PARALLEL];
    logic signed [YW-1:0]          y_next [PARALLEL];
    logic signed [YW-1:0]          s2_y   [PARALLEL];
    logic                          s2_valid, s2_sync, s2_sat;

    logic [DOUT_WIDTH*PARALLEL-1:0] dout_next;
    logic [PARALLEL-1:0]           ovf_next;
    logic [PARALLEL-1:0]           s3_ovf;

    assign en        = !dout_valid || dout_ready;
    assign din_ready = en;
    assign sh_amt    = SAW'(MAX_SHIFT + int'(cfg_shift_q));

    // config registers; shift is clamped to +/-MAX_SHIFT on load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_shift_q <= '0;
            cfg_round_q <= 2'd0;
            cfg_sat_q   <= 1'b1;
        end else if (cfg_we) begin
            if (int'(cfg_shift) > MAX_SHIFT)
                cfg_shift_q <= SHIFT_WIDTH'(MAX_SHIFT);
            else if (int'(cfg_shift) < -MAX_SHIFT)
                cfg_shift_q <= SHIFT_WIDTH'(-MAX_SHIFT);
            else
                cfg_shift_q <= cfg_shift;
            cfg_round_q <= cfg_round;
            cfg_sat_q   <= cfg_sat;
        end
    end

    // align: extend each lane and shift so the binary point sits at DIN_POINT+MAX_SHIFT
    always_comb begin
        for (int i = 0; i < PARALLEL; i++) begin
            x_next[i] = {{(XW + 1 - DIN_WIDTH){IS_SIGNED & din[i*DIN_WIDTH + DIN_WIDTH - 1]}},
                         din[i*DIN_WIDTH +: DIN_WIDTH]};
            x_next[i] = x_next[i] <<< sh_amt;
        end
    end

    // stage 1 register: aligned lanes plus the config this sample was accepted with
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sync  <= 1'b0;
            s1_round <= 2'd0;
            s1_sat   <= 1'b1;
            for (int i = 0; i < PARALLEL; i++) s1_x[i] <= '0;
        end else if (en) begin
            s1_valid <= din_valid;
            s1_sync  <= sync_in;
            s1_round <= cfg_round_q;
            s1_sat   <= cfg_sat_q;
            for (int i = 0; i < PARALLEL; i++) s1_x[i] <= x_next[i];
        end
    end

    // round: add half for modes 1/2 on a guard-extended word; an exact half leaves
    // the dropped bits all zero, which is where mode 2 pulls odd results back to even
    always_comb begin
        for (int i = 0; i < PARALLEL; i++) begin
            rsum[i]   = {s1_x[i][XW], s1_x[i]}
                        + ((s1_round == 2'd1 || s1_round == 2'd2) ? HALF : '0);
            y_next[i] = rsum[i][XW+1:F];
            if (s1_round == 2'd2 && rsum[i][F-1:0] == '0 && y_next[i][0])
                y_next[i] = y_next[i] - YW'(1);
        end
    end

    // stage 2 register: rounded lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sync  <= 1'b0;
            s2_sat   <= 1'b1;
            for (int i = 0; i < PARALLEL; i++) s2_y[i] <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sync  <= s1_sync;
            s2_sat   <= s1_sat;
            for (int i = 0; i < PARALLEL; i++) s2_y[i] <= y_next[i];
        end
    end

    // range: detect overflow, then clamp or keep the low bits
    always_comb begin
        dout_next = '0;
        ovf_next  = '0;
        for (int i = 0; i < PARALLEL; i++) begin
            ovf_next[i] = (s2_y[i] > HI) || (s2_y[i] < LO);
            if (s2_sat && s2_y[i] > HI)
                dout_next[i*DOUT_WIDTH +: DOUT_WIDTH] = HI[DOUT_WIDTH-1:0];
            else if (s2_sat && s2_y[i] < LO)
                dout_next[i*DOUT_WIDTH +: DOUT_WIDTH] = LO[DOUT_WIDTH-1:0];
            else
                dout_next[i*DOUT_WIDTH +: DOUT_WIDTH] = s2_y[i][DOUT_WIDTH-1:0];
        end
    end

    // stage 3 register: output lanes and their overflow marks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_out   <= 1'b0;
            s3_ovf     <= '0;
        end else if (en) begin
            dout       <= dout_next;
            dout_valid <= s2_valid;
            sync_out   <= s2_sync;
            s3_ovf     <= ovf_next;
        end
    end

    // sticky flags set on an overflowing output transfer; set beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warn_flags <= '0;
            warning    <= 1'b0;
        end else begin
            warn_flags <= (warn_flags & ~{PARALLEL{warn_clr}})
                          | (s3_ovf & {PARALLEL{dout_valid && dout_ready}});
            warning    <= |warn_flags;
        end
    end

endmodule

// File: tb/tb_resize_stream.sv
// Directed bench for resize_stream with default lane formats and a 6-bit shift
// port so an out-of-range shift can be presented.
module tb_resize_stream;

    logic              clk;
    logic              rst_n;
    logic [71:0]       din;
    logic              din_valid;
    logic              din_ready;
    logic              sync_in;
    logic [35:0]       dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              sync_out;
    logic              cfg_we;
    logic signed [5:0] cfg_shift;
    logic [1:0]        cfg_round;
    logic              cfg_sat;
    logic              warn_clr;
    logic [3:0]        warn_flags;
    logic              warning;

    int n_cmp = 0;
    int n_err = 0;

    resize_stream #(
        .DIN_WIDTH(18), .DIN_POINT(16), .DOUT_WIDTH(9), .DOUT_POINT(8),
        .DATA_TYPE("signed"), .PARALLEL(4), .MAX_SHIFT(8), .SHIFT_WIDTH(6)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .din(din), .din_valid(din_valid), .din_ready(din_ready), .sync_in(sync_in),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .sync_out(sync_out),
        .cfg_we(cfg_we), .cfg_shift(cfg_shift), .cfg_round(cfg_round), .cfg_sat(cfg_sat),
        .warn_clr(warn_clr), .warn_flags(warn_flags), .warning(warning)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cfg(input logic signed [5:0] sh, input logic [1:0] rnd, input logic st);
        @(negedge clk);
        cfg_shift = sh; cfg_round = rnd; cfg_sat = st; cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // one sample on lanes 0/1; returns on the negedge where it sits on dout
    task automatic send(input logic [17:0] l0, input logic [17:0] l1);
        @(negedge clk);
        din = {36'd0, l1, l0}; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; din = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic logic [71:0] pack(input int k);
        return {36'd0, 18'(k * 512), 18'(k * 256)};
    endfunction

    logic [17:0] rnd_din [3];
    logic [8:0]  rnd_exp [3][3];
    int          send_idx, rx_idx, extra;
    logic        acc, stall;
    logic [35:0] held;

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; sync_in = 1'b0; dout_ready = 1'b1;
        cfg_we = 1'b0; cfg_shift = '0; cfg_round = 2'd0; cfg_sat = 1'b1; warn_clr = 1'b0;

        rnd_din[0] = 18'd384;    rnd_exp[0][0] = 9'd1;     rnd_exp[0][1] = 9'd2;     rnd_exp[0][2] = 9'd2;
        rnd_din[1] = 18'd640;    rnd_exp[1][0] = 9'd2;     rnd_exp[1][1] = 9'd3;     rnd_exp[1][2] = 9'd2;
        rnd_din[2] = -18'sd384;  rnd_exp[2][0] = 9'h1FE;   rnd_exp[2][1] = 9'h1FF;   rnd_exp[2][2] = 9'h1FE;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_sync_out", sync_out, 0);
        chk("rst_warn_flags", warn_flags, 0);
        chk("rst_warning", warning, 0);
        chk("rst_din_ready", din_ready, 1);

        // basic conversion, latency and sync alignment
        @(negedge clk);
        din = {54'd0, 18'd32768}; din_valid = 1'b1; sync_in = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; sync_in = 1'b0; din = '0;
        @(negedge clk);
        chk("lat_not_early", dout_valid, 0);
        @(negedge clk);
        chk("lat_valid", dout_valid, 1);
        chk("half_dout", dout, {27'd0, 9'd128});
        chk("sync_out", sync_out, 1);
        @(negedge clk);
        chk("one_shot_valid", dout_valid, 0);
        chk("one_shot_sync", sync_out, 0);

        // rounding modes
        for (int m = 0; m < 3; m++) begin
            do_cfg(6'sd0, 2'(m), 1'b1);
            for (int v = 0; v < 3; v++) begin
                send(rnd_din[v], 18'd0);
                chk($sformatf("round_m%0d_v%0d", m, v), dout[8:0], rnd_exp[v][m]);
            end
        end
        do_cfg(6'sd0, 2'd3, 1'b1);
        send(18'd640, 18'd384);
        chk("round_m3_l0", dout[8:0], 9'd2);
        chk("round_m3_l1", dout[17:9], 9'd1);

        // overflow, saturate, flag timing
        do_cfg(6'sd1, 2'd0, 1'b1);
        send(18'd65536, 18'd0);
        chk("ovf_sat_dout", dout[8:0], 9'd255);
        chk("ovf_flag_before", warn_flags, 4'b0000);
        @(negedge clk);
        chk("ovf_flag", warn_flags, 4'b0001);
        chk("ovf_warning_lag", warning, 0);
        @(negedge clk);
        chk("ovf_warning", warning, 1);
        warn_clr = 1'b1;
        @(negedge clk);
        warn_clr = 1'b0;
        chk("clr_flags", warn_flags, 4'b0000);
        @(negedge clk);
        chk("clr_warning", warning, 0);

        // wrap mode
        do_cfg(6'sd1, 2'd0, 1'b0);
        send(18'd65536, 18'd0);
        chk("ovf_wrap_dout", dout[8:0], 9'd0);
        @(negedge clk);
        chk("wrap_flag", warn_flags, 4'b0001);
        warn_clr = 1'b1;
        @(negedge clk);
        warn_clr = 1'b0;
        chk("clr2_flags", warn_flags, 4'b0000);

        // clear and set in the same cycle
        send(18'd65536, 18'd0);
        warn_clr = 1'b1;
        @(negedge clk);
        warn_clr = 1'b0;
        chk("set_beats_clr", warn_flags, 4'b0001);

        // negative shift and clamping
        do_cfg(-6'sd3, 2'd0, 1'b1);
        send(18'd65536, 18'd0);
        chk("shift_m3", dout[8:0], 9'd32);
        do_cfg(-6'sd20, 2'd0, 1'b1);
        send(18'd65536, 18'd0);
        chk("shift_clamp", dout[8:0], 9'd1);

        // backpressure stream
        do_cfg(6'sd0, 2'd0, 1'b1);
        @(negedge clk);
        send_idx = 1; rx_idx = 1;
        din = pack(1); din_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && rx_idx <= 10; cyc++) begin
            dout_ready = 1'($urandom_range(0, 1));
            #1;
            chk("bp_din_ready", din_ready, !dout_valid || dout_ready);
            if (dout_valid && dout_ready) begin
                chk($sformatf("bp_l0_%0d", rx_idx), dout[8:0], 9'(rx_idx));
                chk($sformatf("bp_l1_%0d", rx_idx), dout[17:9], 9'(2 * rx_idx));
                rx_idx++;
            end
            acc   = din_valid && din_ready;
            stall = dout_valid && !dout_ready;
            held  = dout;
            @(negedge clk);
            if (stall) begin
                chk("bp_hold_dout", dout, held);
                chk("bp_hold_valid", dout_valid, 1);
            end
            if (acc) begin
                send_idx++;
                if (send_idx <= 10) din = pack(send_idx);
                else begin din_valid = 1'b0; din = '0; end
            end
        end
        chk("bp_count", rx_idx, 11);
        dout_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (dout_valid) extra++;
        end
        chk("bp_no_dup", extra, 0);

        // reset mid-stream with non-default config and a set flag
        do_cfg(-6'sd3, 2'd2, 1'b0);
        @(negedge clk);
        din = pack(1); din_valid = 1'b1; sync_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", dout_valid, 1);
        rst_n = 1'b0; din_valid = 1'b0; sync_in = 1'b0; din = '0;
        #1;
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_sync", sync_out, 0);
        chk("mid_rst_flags", warn_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (dout_valid || sync_out) extra++;
        end
        chk("post_rst_stale", extra, 0);
        send(18'd65536, 18'd384);
        chk("post_rst_sat_shift", dout[8:0], 9'd255);
        chk("post_rst_round", dout[17:9], 9'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
